// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder controller:
//   - state_e       : controller state encoding (IDLE=0, RUN=1, DONE=2)
//   - DEFAULT_WIDTH : default operand/sum width
//   - cnt_width()   : bit counter width, max(1, ceil(log2(width)))
// ---------------------------------------------------------------------------
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // $clog2(1) is 0, but the counter always needs at least one bit.
  function automatic int cnt_width(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage : serial_adder_pkg

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
// Single-bit combinational full adder.
// Ports:
//   a, b, c : addend bits and carry-in
//   s       : sum bit
//   cy      : carry-out
// ---------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic cy
);

  assign s  = a ^ b ^ c;
  assign cy = (a & b) | (a & c) | (b & c);

endmodule : full_adder

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
// Bit-serial adder: sequences one full_adder over WIDTH cycles to compute
// {cout, sum} = a_in + b_in + cin, LSB first.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : request, sampled in IDLE or DONE only
//   a_in, b_in, cin : operands, captured on an accepted start
//   busy            : high whenever the controller is not IDLE
//   done            : one-cycle pulse, sum/cout valid in the same cycle
//   sum, cout       : registered result, held until the next completion
// ---------------------------------------------------------------------------
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);
  // The result shift register only needs the bits collected before the
  // final cycle; the last sum bit comes straight from the adder.
  localparam int SW = (WIDTH > 1) ? WIDTH - 1 : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [SW-1:0]    s_q, s_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             fa_s, fa_cy;
  logic [WIDTH-1:0] sum_next;
  logic [SW-1:0]    s_shift;
  logic             last_bit;

  full_adder u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .c  (carry_q),
    .s  (fa_s),
    .cy (fa_cy)
  );

  // sum_next is the full result if this is the final RUN cycle; s_shift is
  // the partial result register after inserting this cycle's bit at the MSB.
  if (WIDTH == 1) begin : gen_w1
    assign sum_next = fa_s;
    assign s_shift  = s_q;
  end else begin : gen_wn
    logic [WIDTH-1:0] s_full;
    assign s_full   = {fa_s, s_q};
    assign sum_next = s_full;
    assign s_shift  = s_full[WIDTH-1:1];
  end

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        s_d     = s_shift;
        carry_d = fa_cy;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          sum_d   = sum_next;
          cout_d  = fa_cy;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
// Directed and random checks of serial_adder_ctrl at WIDTH=8, plus
// exhaustive checks of WIDTH=3 and WIDTH=1 instances. Expected results are
// plain integer sums of the operands.
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;

  localparam int W8 = 8;
  localparam int W3 = 3;
  localparam int W1 = 1;
  localparam int TMO = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic          start8 = 1'b0, cin8 = 1'b0;
  logic [W8-1:0] a8 = '0, b8 = '0;
  logic          busy8, done8, cout8;
  logic [W8-1:0] sum8;

  // WIDTH=3 instance
  logic          start3 = 1'b0, cin3 = 1'b0;
  logic [W3-1:0] a3 = '0, b3 = '0;
  logic          busy3, done3, cout3;
  logic [W3-1:0] sum3;

  // WIDTH=1 instance
  logic          start1 = 1'b0, cin1 = 1'b0;
  logic [W1-1:0] a1 = '0, b1 = '0;
  logic          busy1, done1, cout1;
  logic [W1-1:0] sum1;

  serial_adder_ctrl #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );
  serial_adder_ctrl #(.WIDTH(W3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a_in(a3), .b_in(b3), .cin(cin3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
  );
  serial_adder_ctrl #(.WIDTH(W1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result: the sum of the operands, as an integer.
  function automatic logic [31:0] ref_add(input int a, input int b, input int c);
    return a + b + c;
  endfunction

  // One WIDTH=8 operation: start for one edge, then wait for done.
  // lat counts edges after the start edge until done is seen.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int lat, bcnt;
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    bcnt = busy8 ? 1 : 0;
    while (!done8 && lat < TMO) begin
      @(posedge clk); #1;
      lat++;
      if (busy8) bcnt++;
    end
    check("w8_latency", lat, W8);
    check("w8_busy_cycles", bcnt, W8 + 1);
    check("w8_result", {cout8, sum8}, ref_add(a, b, c));
    $display("w8 op a=%02h b=%02h cin=%0d -> cout=%0d sum=%02h lat=%0d", a, b, c, cout8, sum8, lat);
  endtask

  task automatic op3(input int a, input int b, input int c);
    int lat;
    a3 = W3'(a); b3 = W3'(b); cin3 = c[0]; start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    lat = 0;
    while (!done3 && lat < TMO) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w3_latency", lat, W3);
    check("w3_result", {cout3, sum3}, ref_add(a, b, c));
    $display("w3 op a=%0d b=%0d cin=%0d -> cout=%0d sum=%0d lat=%0d", a, b, c, cout3, sum3, lat);
  endtask

  task automatic op1(input int a, input int b, input int c);
    int lat;
    a1 = W1'(a); b1 = W1'(b); cin1 = c[0]; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    lat = 0;
    while (!done1 && lat < TMO) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w1_latency", lat, W1);
    check("w1_result", {cout1, sum1}, ref_add(a, b, c));
    $display("w1 op a=%0d b=%0d cin=%0d -> cout=%0d sum=%0d lat=%0d", a, b, c, cout1, sum1, lat);
  endtask

  initial begin
    int n, ndone;
    logic [7:0] ra, rb;
    logic rc;

    // Reset state
    #1;
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_sum", sum8, 0);
    check("rst_cout", cout8, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic operation, then done must be a single-cycle pulse
    op8(8'h5A, 8'h33, 1'b0);
    check("basic_sum", sum8, 8'h8D);
    @(posedge clk); #1;
    check("done_pulse_width", done8, 0);
    check("idle_busy", busy8, 0);
    check("idle_hold_sum", sum8, 8'h8D);

    // Carry boundary cases
    op8(8'hFF, 8'h01, 1'b0);
    op8(8'hFF, 8'hFF, 1'b1);
    op8(8'h00, 8'h00, 1'b1);
    @(posedge clk); #1;

    // start held high: back-to-back operations
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!done8 && n < TMO) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_first_lat", n, W8);
    check("b2b_first_result", {cout8, sum8}, 9'h030);
    a8 = 8'h7F; b8 = 8'h01;
    @(posedge clk); #1;
    n = 1;
    while (!done8 && n < TMO) begin
      if (n == 4) check("b2b_sum_hold", sum8, 8'h30);
      @(posedge clk); #1;
      n++;
    end
    check("b2b_done_gap", n, W8 + 1);
    check("b2b_second_result", {cout8, sum8}, 9'h080);
    $display("b2b second op -> cout=%0d sum=%02h gap=%0d", cout8, sum8, n);
    start8 = 1'b0;
    @(posedge clk); #1;

    // start during RUN is ignored
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 0;
    @(posedge clk); #1; n++;
    @(posedge clk); #1; n++;
    a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1; n++;
    start8 = 1'b0;
    while (!done8 && n < TMO) begin
      @(posedge clk); #1;
      n++;
    end
    check("ignore_lat", n, W8);
    check("ignore_result", {cout8, sum8}, ref_add(8'h12, 8'h34, 1));
    $display("ignore-start op -> cout=%0d sum=%02h", cout8, sum8);
    @(posedge clk); #1;
    check("ignore_no_extra_busy", busy8, 0);
    check("ignore_no_extra_done", done8, 0);

    // Asynchronous reset mid-RUN
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("abort_busy", busy8, 0);
    check("abort_done", done8, 0);
    check("abort_sum", sum8, 0);
    check("abort_cout", cout8, 0);
    $display("reset mid-run -> busy=%0d sum=%02h", busy8, sum8);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8) ndone++;
    end
    check("abort_no_done", ndone, 0);
    op8(8'h01, 8'h01, 1'b0);
    check("post_abort_sum", sum8, 8'h02);
    @(posedge clk); #1;

    // Random WIDTH=8 operations
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      op8(ra, rb, rc);
      if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
    end

    // Exhaustive small widths
    for (int a = 0; a < (1 << W3); a++)
      for (int b = 0; b < (1 << W3); b++)
        for (int c = 0; c < 2; c++)
          op3(a, b, c);
    for (int a = 0; a < (1 << W1); a++)
      for (int b = 0; b < (1 << W1); b++)
        for (int c = 0; c < 2; c++)
          op1(a, b, c);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_serial_adder_ctrl
